y86_decode_stage: RTL

Decode/write-back stage of the 5-stage pipelined Y86-64 processor. It reads the 15-entry register file, selects operands through five-source forwarding, computes source and destination register IDs, and loads the D→E pipeline register that feeds the execute stage's ALU and condition logic. Write-back ports from the W stage update the register file in the same block.

---
 rtl/y86_decode_stage.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/y86_decode_stage.sv
// Y86-64 decode/write-back stage: register file, five-source operand forwarding,
// register-ID decode and the D->E pipeline register.
module y86_decode_stage #(
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] RRSP  = 4'h4,
  parameter logic [2:0] SAOK  = 3'd1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  D_stat,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic        E_stall,
  input  logic        E_bubble,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [2:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB
);

  localparam logic [3:0] I_NOP   = 4'h1;
  localparam logic [3:0] I_RRMOV = 4'h2;
  localparam logic [3:0] I_IRMOV = 4'h3;
  localparam logic [3:0] I_RMMOV = 4'h4;
  localparam logic [3:0] I_MRMOV = 4'h5;
  localparam logic [3:0] I_OP    = 4'h6;
  localparam logic [3:0] I_JXX   = 4'h7;
  localparam logic [3:0] I_CALL  = 4'h8;
  localparam logic [3:0] I_RET   = 4'h9;
  localparam logic [3:0] I_PUSH  = 4'hA;
  localparam logic [3:0] I_POP   = 4'hB;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] val_c;
    logic [63:0] val_a;
    logic [63:0] val_b;
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic [3:0]  src_a;
    logic [3:0]  src_b;
  } e_reg_t;

  logic [3:0]        d_dst_e;
  logic [3:0]        d_dst_m;
  logic [63:0]       d_val_a;
  logic [63:0]       d_val_b;
  logic [15:0][63:0] rf_rd;
  e_reg_t            e_reg;
  e_reg_t            e_next;
  e_reg_t            bubble_val;

  // Register file; slot 15 of the read vector is a constant zero so RNONE reads 0.
  genvar gi;
  generate
    for (gi = 0; gi < 15; gi++) begin : g_rf
      localparam logic [3:0] REG_ID = 4'(gi);
      logic [63:0] q_reg;
      always_ff @(posedge clock) begin
        if (reset) begin
          q_reg <= '0;
        end else if (W_dstM == REG_ID) begin
          q_reg <= W_valM;
        end else if (W_dstE == REG_ID) begin
          q_reg <= W_valE;
        end
      end
      assign rf_rd[gi] = q_reg;
    end
  endgenerate
  assign rf_rd[15] = '0;

  always_comb begin
    d_srcA  = RNONE;
    d_srcB  = RNONE;
    d_dst_e = RNONE;
    d_dst_m = RNONE;
    case (D_icode)
      I_RRMOV, I_RMMOV, I_OP, I_PUSH: d_srcA = D_rA;
      I_RET, I_POP:                   d_srcA = RRSP;
      default:                        d_srcA = RNONE;
    endcase
    case (D_icode)
      I_RMMOV, I_MRMOV, I_OP:         d_srcB = D_rB;
      I_CALL, I_RET, I_PUSH, I_POP:   d_srcB = RRSP;
      default:                        d_srcB = RNONE;
    endcase
    case (D_icode)
      I_RRMOV, I_IRMOV, I_OP:         d_dst_e = D_rB;
      I_CALL, I_RET, I_PUSH, I_POP:   d_dst_e = RRSP;
      default:                        d_dst_e = RNONE;
    endcase
    case (D_icode)
      I_MRMOV, I_POP:                 d_dst_m = D_rA;
      default:                        d_dst_m = RNONE;
    endcase
  end

  // Forwarding: youngest producer wins; a source of RNONE never matches anything.
  always_comb begin
    d_val_a = (d_srcA == RNONE) ? '0 : rf_rd[d_srcA];
    if (D_icode == I_JXX || D_icode == I_CALL) begin
      d_val_a = D_valP;
    end else if (d_srcA != RNONE) begin
      if (e_dstE == d_srcA)      d_val_a = e_valE;
      else if (M_dstM == d_srcA) d_val_a = m_valM;
      else if (M_dstE == d_srcA) d_val_a = M_valE;
      else if (W_dstM == d_srcA) d_val_a = W_valM;
      else if (W_dstE == d_srcA) d_val_a = W_valE;
    end
  end

  always_comb begin
    d_val_b = (d_srcB == RNONE) ? '0 : rf_rd[d_srcB];
    if (d_srcB != RNONE) begin
      if (e_dstE == d_srcB)      d_val_b = e_valE;
      else if (M_dstM == d_srcB) d_val_b = m_valM;
      else if (M_dstE == d_srcB) d_val_b = M_valE;
      else if (W_dstM == d_srcB) d_val_b = W_valM;
      else if (W_dstE == d_srcB) d_val_b = W_valE;
    end
  end

  always_comb begin
    bubble_val       = '0;
    bubble_val.stat  = SAOK;
    bubble_val.icode = I_NOP;
    bubble_val.dst_e = RNONE;
    bubble_val.dst_m = RNONE;
    bubble_val.src_a = RNONE;
    bubble_val.src_b = RNONE;

    e_next = e_reg;
    if (E_bubble) begin
      e_next = bubble_val;
    end else if (!E_stall) begin
      e_next.stat  = D_stat;
      e_next.icode = D_icode;
      e_next.ifun  = D_ifun;
      e_next.val_c = D_valC;
      e_next.val_a = d_val_a;
      e_next.val_b = d_val_b;
      e_next.dst_e = d_dst_e;
      e_next.dst_m = d_dst_m;
      e_next.src_a = d_srcA;
      e_next.src_b = d_srcB;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      e_reg <= bubble_val;
    end else begin
      e_reg <= e_next;
    end
  end

  assign E_stat  = e_reg.stat;
  assign E_icode = e_reg.icode;
  assign E_ifun  = e_reg.ifun;
  assign E_valC  = e_reg.val_c;
  assign E_valA  = e_reg.val_a;
  assign E_valB  = e_reg.val_b;
  assign E_dstE  = e_reg.dst_e;
  assign E_dstM  = e_reg.dst_m;
  assign E_srcA  = e_reg.src_a;
  assign E_srcB  = e_reg.src_b;

endmodule
